// File: rtl/axi_rd_stream_sched_pkg.sv
// axi_rd_stream_sched_pkg: shared FSM states, AXI constants and stream address layout
package axi_rd_stream_sched_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [2:0] ARSIZE_64B = 3'b110;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam int BEAT_BYTES = 64;
  localparam int STREAM_BYTES_DEF = 230400;
  localparam int STREAM_ADDR_SHIFT_DEF = 2;
  // Base address of a stream region; monitor and generators must agree on this layout
  function automatic logic [31:0] stream_base(input logic [7:0] s, input int off, input int sh);
    return {24'd0, s} << (off + sh);
  endfunction
endpackage

// File: rtl/axi_outstanding_cnt.sv
// axi_outstanding_cnt: up/down burst credit counter with limit and underflow flag
module axi_outstanding_cnt #(
  parameter int MAX = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         can_issue,
  output logic         underflow
);
  logic [W-1:0] cnt_nxt;
  always_comb begin
    cnt_nxt = (inc && !dec) ? count + 1'b1 : (dec && !inc && count != '0) ? count - 1'b1 : count;
  end
  assign can_issue = count < W'(MAX);
  assign underflow = dec && count == '0;
  always_ff @(posedge clk) begin
    if (!reset_n) count <= '0;
    else count <= cnt_nxt;
  end
endmodule

// File: rtl/axi_rd_stream_sched.sv
// axi_rd_stream_sched: in-order AXI4 read burst sequencer replaying DDR4 test streams
module axi_rd_stream_sched
  import axi_rd_stream_sched_pkg::*;
#(
  parameter int STREAM_BYTES = STREAM_BYTES_DEF,
  parameter int STREAM_ADDR_SHIFT = STREAM_ADDR_SHIFT_DEF,
  parameter int STREAM_ADDR_OFFSET = $clog2(STREAM_BYTES),
  parameter int BURST_LEN = 16,
  parameter int BURSTS_PER_STREAM = STREAM_BYTES / (BURST_LEN * BEAT_BYTES),
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  num_streams,
  input  logic [7:0]  num_iters,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARID,
  output logic [7:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic        RVALID,
  input  logic        RLAST,
  input  logic [3:0]  RID,
  output logic        RREADY,
  output logic        busy,
  output logic        done,
  output logic [7:0]  cur_stream,
  output logic [7:0]  cur_iter,
  output logic        proto_err
);
  localparam int BW = $clog2(BURSTS_PER_STREAM + 1);
  localparam logic [BW-1:0] BPS = BW'(BURSTS_PER_STREAM);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * BEAT_BYTES);
  logic [1:0] state;
  logic [BW-1:0] burst_idx, idx_nxt;
  logic [7:0] ns_q, ni_q;
  logic [3:0] count;
  logic stop_flag, stop_eff, pend, hs, comp, can_issue, underflow, drained, last_s, last_i, start_ok;
  axi_outstanding_cnt #(.MAX(MAX_OUTSTANDING), .W(4)) u_cnt (
    .clk(clk), .reset_n(reset_n), .inc(hs), .dec(comp),
    .count(count), .can_issue(can_issue), .underflow(underflow)
  );
  assign ARADDR = stream_base(cur_stream, STREAM_ADDR_OFFSET, STREAM_ADDR_SHIFT) + 32'(burst_idx) * BURST_BYTES;
  assign ARID = cur_stream[3:0];
  assign ARLEN = 8'(BURST_LEN - 1);
  assign ARSIZE = ARSIZE_64B;
  assign ARBURST = BURST_INCR;
  // A raised request is held by pend so a late stop cannot withdraw it before ARREADY
  assign ARVALID = state == S_ISSUE && (pend || (can_issue && burst_idx < BPS && !stop_flag));
  assign hs = ARVALID && ARREADY;
  assign comp = RVALID && RREADY && RLAST;
  assign idx_nxt = burst_idx + BW'(hs);
  assign stop_eff = stop || stop_flag;
  assign drained = count == 4'd0 || (count == 4'd1 && comp);
  assign last_s = cur_stream == ns_q - 8'd1;
  assign last_i = cur_iter == ni_q - 8'd1;
  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign busy = state == S_ISSUE || state == S_DRAIN;
  assign done = state == S_DONE;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      burst_idx <= '0;
      cur_stream <= 8'd0;
      cur_iter <= 8'd0;
      ns_q <= 8'd1;
      ni_q <= 8'd1;
      stop_flag <= 1'b0;
      pend <= 1'b0;
      proto_err <= 1'b0;
      RREADY <= 1'b0;
    end else begin
      RREADY <= 1'b1;
      pend <= ARVALID && !ARREADY;
      proto_err <= proto_err || underflow || (busy && RVALID && RID != cur_stream[3:0]);
      if (start_ok) begin
        ns_q <= num_streams == 8'd0 ? 8'd1 : num_streams;
        ni_q <= num_iters == 8'd0 ? 8'd1 : num_iters;
        cur_stream <= 8'd0;
        cur_iter <= 8'd0;
        burst_idx <= '0;
        stop_flag <= 1'b0;
        state <= S_ISSUE;
      end
      if (state == S_ISSUE) begin
        burst_idx <= idx_nxt;
        stop_flag <= stop_eff;
        if (idx_nxt == BPS || (stop_eff && !(ARVALID && !ARREADY))) state <= S_DRAIN;
      end
      if (state == S_DRAIN) begin
        stop_flag <= stop_eff;
        if (drained) begin
          if (stop_eff || (last_s && last_i)) state <= S_DONE;
          else begin
            state <= S_ISSUE;
            burst_idx <= '0;
            cur_stream <= last_s ? 8'd0 : cur_stream + 8'd1;
            cur_iter <= last_s ? cur_iter + 8'd1 : cur_iter;
          end
        end
      end
    end
  end
endmodule
